// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack transaction per load/store,
// stalling the pipeline until ack or timeout; sticky timeout flag, saturating stall counter.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic                access;
    logic                stall;

    assign access = MemRead_i | MemWrite_i;
    // Gated by reset so the pipeline is released the instant reset asserts.
    assign stall  = rst_i & (((state_q == IDLE) & access) | (state_q == REQ));

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_we_d    = MemWrite_i;
                    mem_addr_d  = addr_i;
                    mem_wdata_d = wdata_i;
                    to_cnt_d    = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a simultaneous timeout.
                if (mem_ack_i) begin
                    if (!mem_we_q) rdata_d = mem_rdata_i;
                    state_d = DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ABORT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DONE, ABORT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o     = stall;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: load/store latency, back-to-back, timeout, reset abort.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 200;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    int stalls, reqs, bad;

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    // Issues one access and returns in the DONE/ABORT cycle, inputs still held.
    // ack_after < 0 means no ack is ever given.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_after, input logic [31:0] rd,
                              output int n_stall, output int n_req, output int n_bad);
        @(posedge clk_i); #1;
        MemRead_i = ~we; MemWrite_i = we; addr_i = addr; wdata_i = wd;
        n_stall = 0; n_req = 0; n_bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (!stall_o) break;
            n_stall++;
            if (mem_req_o) begin
                if (mem_addr_o !== addr || mem_wdata_o !== wd || mem_we_o !== we) n_bad++;
                if (n_req == ack_after) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rd;
                end
                n_req++;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        #12;
        check("rst_stall",  {63'd0, stall_o},   64'd0);
        check("rst_req",    {63'd0, mem_req_o}, 64'd0);
        check("rst_err",    {63'd0, err_o},     64'd0);
        check("rst_rdata",  {32'd0, rdata_o},   64'd0);
        check("rst_cnt",    {32'd0, stall_cnt_o}, 64'd0);
        check("rst_addr",   {32'd0, mem_addr_o},  64'd0);
        #1 rst_i = 1'b1;

        // T1: zero-wait load
        run_access(1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, stalls, reqs, bad);
        check("t1_stalls", 64'(stalls), 64'd2);
        check("t1_reqs",   64'(reqs),   64'd1);
        check("t1_stable", 64'(bad),    64'd0);
        check("t1_rdata",  {32'd0, rdata_o}, 64'hDEADBEEF);
        check("t1_we",     {63'd0, mem_we_o}, 64'd0);
        check("t1_donereq", {63'd0, mem_req_o}, 64'd0);
        idle_cycle();

        // T2: store, ack after 5 waiting REQ cycles
        run_access(1'b1, 32'h80, 32'h1234, 5, 32'hFFFF0000, stalls, reqs, bad);
        check("t2_stalls", 64'(stalls), 64'd7);
        check("t2_reqs",   64'(reqs),   64'd6);
        check("t2_stable", 64'(bad),    64'd0);
        check("t2_we",     {63'd0, mem_we_o}, 64'd1);
        check("t2_rdata_hold", {32'd0, rdata_o}, 64'hDEADBEEF);
        check("t2_cnt",    {32'd0, stall_cnt_o}, 64'd9);
        idle_cycle();

        // T3: back-to-back zero-wait loads from a cleared counter
        do_reset();
        run_access(1'b0, 32'h100, 32'h0, 0, 32'h11111111, stalls, reqs, bad);
        check("t3a_stalls", 64'(stalls), 64'd2);
        check("t3a_rdata",  {32'd0, rdata_o}, 64'h11111111);
        check("t3a_noreissue", {63'd0, mem_req_o}, 64'd0);
        run_access(1'b0, 32'h104, 32'h0, 0, 32'h22222222, stalls, reqs, bad);
        check("t3b_stalls", 64'(stalls), 64'd2);
        check("t3b_reqs",   64'(reqs),   64'd1);
        check("t3b_addr",   {32'd0, mem_addr_o}, 64'h104);
        check("t3b_rdata",  {32'd0, rdata_o}, 64'h22222222);
        check("t3_cnt",     {32'd0, stall_cnt_o}, 64'd4);
        idle_cycle();

        // Spurious ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        @(posedge clk_i); #1 mem_ack_i = 1'b0;
        #1;
        check("spur_rdata", {32'd0, rdata_o},   64'h22222222);
        check("spur_req",   {63'd0, mem_req_o}, 64'd0);
        check("spur_stall", {63'd0, stall_o},   64'd0);

        // T5: ack exactly when counter reaches TIMEOUT-1
        run_access(1'b0, 32'h200, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5, stalls, reqs, bad);
        check("t5_stalls", 64'(stalls), 64'(TIMEOUT + 1));
        check("t5_err",    {63'd0, err_o},   64'd0);
        check("t5_rdata",  {32'd0, rdata_o}, 64'hA5A5A5A5);
        idle_cycle();

        // T4: no ack -> abort after TIMEOUT REQ cycles
        run_access(1'b0, 32'h300, 32'h0, -1, 32'h0, stalls, reqs, bad);
        check("t4_reqs",   64'(reqs),   64'(TIMEOUT));
        check("t4_stalls", 64'(stalls), 64'(TIMEOUT + 1));
        check("t4_err",    {63'd0, err_o},   64'd1);
        check("t4_rdata",  {32'd0, rdata_o}, 64'd0);
        idle_cycle();
        run_access(1'b0, 32'h304, 32'h0, 2, 32'hCAFEF00D, stalls, reqs, bad);
        check("t4_next_stalls", 64'(stalls), 64'd4);
        check("t4_next_rdata",  {32'd0, rdata_o}, 64'hCAFEF00D);
        check("t4_err_sticky",  {63'd0, err_o},   64'd1);
        idle_cycle();

        // T6: reset asserted mid-REQ
        MemRead_i = 1'b1; addr_i = 32'h400;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("t6_inreq", {63'd0, mem_req_o}, 64'd1);
        #2 rst_i = 1'b0;
        #1;
        check("t6_req",   {63'd0, mem_req_o},   64'd0);
        check("t6_stall", {63'd0, stall_o},     64'd0);
        check("t6_cnt",   {32'd0, stall_cnt_o}, 64'd0);
        check("t6_err",   {63'd0, err_o},       64'd0);
        check("t6_rdata", {32'd0, rdata_o},     64'd0);
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
        @(posedge clk_i); #1 mem_ack_i = 1'b0;
        #1;
        check("t6_postack_rdata", {32'd0, rdata_o},   64'd0);
        check("t6_postack_req",   {63'd0, mem_req_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
